// File: rtl/lvds_tx_serializer.sv
// LVDS byte-link transmitter: 256x8 FIFO feeding a 2-bit-per-clk serializer
// that frames each burst as zero preamble, sync byte, then payload bytes.
//
// Ports:
//   clk            single clock, also the DDR pad clock
//   reset          asynchronous, active-high
//   wr_en/wr_data  one byte per cycle into the FIFO
//   wr_full        FIFO holds 255 bytes, further writes are dropped
//   wr_almost_full byte count >= AF_LEVEL
//   wr_count       bytes currently held
//   overflow       sticky, a write arrived while full
//   busy           serializer is not idle
//   tx_dout        dibit to the DDR pad, [1] on rising half, [0] on falling

module lvds_tx_serializer #(
    parameter int unsigned ZERO_LEN  = 10,
    parameter logic [7:0]  SYNC_WORD = 8'hD5,
    parameter int unsigned AF_LEVEL  = 224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_full,
    output logic       wr_almost_full,
    output logic [7:0] wr_count,
    output logic       overflow,
    output logic       busy,
    output logic [1:0] tx_dout
);

    localparam logic [7:0] PRE_LAST = 8'(ZERO_LEN / 2 - 1);
    localparam logic [8:0] AF_THR   = 9'(AF_LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        SYNC,
        DATA
    } state_t;

    state_t     state;
    logic [7:0] mem [256];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [7:0] pre_cnt;
    logic [7:0] shreg;
    logic [1:0] dib_cnt;
    logic       wr_ok;
    logic       pop;

    // Full is taken from the registered count, so a write while full is
    // dropped even if a pop frees a slot on the same edge.
    assign wr_ok = wr_en && !wr_full;

    // The next byte is pulled on the last dibit of the sync word or of a
    // payload byte; in DATA only when something is waiting, so the
    // shifter reloads with no gap.
    assign pop = (dib_cnt == 2'd3) &&
                 ((state == SYNC) ||
                  ((state == DATA) && (count != 8'd0)));

    assign wr_count = count;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, pop})
            2'b10:   count_nxt = count + 8'd1;
            2'b01:   count_nxt = count - 8'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= 8'd0;
            rd_ptr         <= 8'd0;
            count          <= 8'd0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 8'd1;
            end
            count          <= count_nxt;
            wr_full        <= (count_nxt == 8'hFF);
            wr_almost_full <= ({1'b0, count_nxt} >= AF_THR);
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx_dout <= 2'b00;
            busy    <= 1'b0;
            pre_cnt <= 8'd0;
            shreg   <= 8'd0;
            dib_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx_dout <= 2'b00;
                    if (count != 8'd0) begin
                        state   <= PRE;
                        pre_cnt <= PRE_LAST;
                        busy    <= 1'b1;
                    end
                end
                PRE: begin
                    tx_dout <= 2'b00;
                    if (pre_cnt == 8'd0) begin
                        state   <= SYNC;
                        shreg   <= SYNC_WORD;
                        dib_cnt <= 2'd0;
                    end else begin
                        pre_cnt <= pre_cnt - 8'd1;
                    end
                end
                SYNC, DATA: begin
                    tx_dout <= shreg[7:6];
                    shreg   <= {shreg[5:0], 2'b00};
                    dib_cnt <= dib_cnt + 2'd1;
                    if (dib_cnt == 2'd3) begin
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_dout <= 2'b00;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Scoreboard bench for lvds_tx_serializer: a burst-level line model
// predicts every cycle, and a line receiver checks decoded payload order.

module tb_lvds_tx_serializer;

    localparam int         ZL  = 10;
    localparam logic [7:0] SW  = 8'hD5;
    localparam int         AFL = 224;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_full;
    logic       wr_almost_full;
    logic [7:0] wr_count;
    logic       overflow;
    logic       busy;
    logic [1:0] tx_dout;

    always #5 clk = ~clk;

    lvds_tx_serializer #(
        .ZERO_LEN (ZL),
        .SYNC_WORD(SW),
        .AF_LEVEL (AFL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_count      (wr_count),
        .overflow      (overflow),
        .busy          (busy),
        .tx_dout       (tx_dout)
    );

    typedef struct packed {
        logic [1:0] dout;
        logic       busy;
        logic [7:0] cnt;
        logic       full;
        logic       af;
        logic       ovf;
    } rec_t;

    int errors = 0;
    int checks = 0;

    rec_t       exp_q[$];
    logic [1:0] lineq[$];
    logic [7:0] mfifo[$];
    logic [7:0] sb_q[$];
    bit         m_active = 1'b0;
    bit         m_ovf    = 1'b0;

    int         max_cnt    = 0;
    int         busy_falls = 0;
    int         af_rises   = 0;
    int         af_falls   = 0;
    int         rx_bytes   = 0;
    logic       prev_busy  = 1'b0;
    logic       prev_af    = 1'b0;
    bit         rx_data    = 1'b0;
    int         rx_n       = 0;
    int         zrun       = 0;
    logic [7:0] rx_sh      = 8'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            lineq.push_back(b[7-2*k -: 2]);
        end
    endfunction

    // Line model: a burst is a queue of dibits (preamble, sync, then each
    // byte as it is taken). A new byte is taken on the edge that sends the
    // last dibit of the previous unit, if the FIFO held one before that edge.
    always @(posedge clk or posedge reset) begin : model
        int         n;
        logic [1:0] d;
        logic [7:0] b;
        rec_t       r;
        if (reset) begin
            exp_q.delete();
            lineq.delete();
            mfifo.delete();
            sb_q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            n = mfifo.size();
            d = 2'b00;
            if (lineq.size() != 0) begin
                d = lineq.pop_front();
            end
            if (!m_active) begin
                if (n != 0) begin
                    m_active = 1'b1;
                    repeat (ZL / 2) lineq.push_back(2'b00);
                    push_byte(SW);
                end
            end else if (lineq.size() == 0) begin
                if (n != 0) begin
                    b = mfifo.pop_front();
                    push_byte(b);
                end else begin
                    m_active = 1'b0;
                end
            end
            if (wr_en) begin
                if (n == 255) begin
                    m_ovf = 1'b1;
                end else begin
                    mfifo.push_back(wr_data);
                    sb_q.push_back(wr_data);
                end
            end
            r.dout = d;
            r.busy = m_active;
            r.cnt  = 8'(mfifo.size());
            r.full = (mfifo.size() == 255);
            r.af   = (mfifo.size() >= AFL);
            r.ovf  = m_ovf;
            exp_q.push_back(r);
        end
    end

    always @(negedge clk) begin : monitor
        rec_t       a;
        rec_t       e;
        logic [7:0] b;
        if (reset) begin
            rx_data   = 1'b0;
            rx_n      = 0;
            zrun      = 0;
            prev_busy = 1'b0;
            prev_af   = 1'b0;
        end else begin
            a = {tx_dout, busy, wr_count, wr_full, wr_almost_full, overflow};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cycle", 64'(a), 64'(e));
            end
            if (int'(wr_count) > max_cnt) max_cnt = int'(wr_count);
            if (prev_busy && !busy) busy_falls++;
            if (wr_almost_full && !prev_af) begin
                af_rises++;
                check("af_rise_count", 64'(wr_count), 64'(AFL));
            end
            if (!wr_almost_full && prev_af) begin
                af_falls++;
                check("af_fall_count", 64'(wr_count), 64'(AFL - 1));
            end
            prev_busy = busy;
            prev_af   = wr_almost_full;

            if (!rx_data) begin
                if (rx_n == 0) begin
                    if (tx_dout == 2'b00) begin
                        zrun++;
                    end else begin
                        check("preamble_min", 64'(zrun >= ZL / 2), 64'd1);
                        rx_sh = {6'd0, tx_dout};
                        rx_n  = 1;
                    end
                end else begin
                    rx_sh = {rx_sh[5:0], tx_dout};
                    rx_n++;
                    if (rx_n == 4) begin
                        check("sync_word", 64'(rx_sh), 64'(SW));
                        rx_data = 1'b1;
                        rx_n    = 0;
                    end
                end
            end else begin
                rx_sh = {rx_sh[5:0], tx_dout};
                rx_n++;
                if (rx_n == 4) begin
                    rx_n = 0;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL payload: got %0h, expected no byte",
                                 rx_sh);
                    end else begin
                        b = sb_q.pop_front();
                        rx_bytes++;
                        if (rx_sh !== b) begin
                            errors++;
                            $display("FAIL payload: got %0h, expected %0h",
                                     rx_sh, b);
                        end
                    end
                    if (!busy) begin
                        rx_data = 1'b0;
                        zrun    = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int limit);
        int c;
        c = 0;
        while ((m_active || mfifo.size() != 0) && c < limit) begin
            tick();
            c++;
        end
        check(name, 64'(c < limit), 64'd1);
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [27:0] cap;
        int          iter;
        int          gap;
        int          len;

        repeat (3) tick();
        check("reset_outs",
              64'({tx_dout, busy, wr_count, wr_full, wr_almost_full, overflow}),
              64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // 1) single byte: 5x00, D5, 9C, then idle
        wr(8'h9C);
        tick();
        cap = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            cap = {cap[25:0], tx_dout};
        end
        check("t1_line", 64'(cap), 64'h0035670);
        wait_drain("t1_drain", 100);

        // 2) back-to-back bytes form one burst
        busy_falls = 0;
        wr(8'h00);
        wr(8'hFF);
        wait_drain("t2_drain", 100);
        check("t2_one_burst", 64'(busy_falls), 64'd1);

        // 3) fill to full, one dropped write, then drain
        af_rises = 0;
        af_falls = 0;
        iter     = 0;
        while (mfifo.size() != 255 && iter < 2000) begin
            wr(8'($urandom));
            iter++;
        end
        check("t3_full", 64'(wr_full), 64'd1);
        check("t3_count", 64'(wr_count), 64'd255);
        wr(8'hA5);
        check("t3_overflow", 64'(overflow), 64'd1);
        wait_drain("t3_drain", 3000);
        check("t3_count_zero", 64'(wr_count), 64'd0);
        check("t3_af_rises", 64'(af_rises), 64'd1);
        check("t3_af_falls", 64'(af_falls), 64'd1);
        pulse_reset();
        check("t3_ovf_cleared", 64'(overflow), 64'd0);

        // 4) ramp 0..599 at one byte per 4 clk, single burst
        max_cnt    = 0;
        busy_falls = 0;
        wr(8'd0);
        repeat (7) tick();
        for (int k = 1; k < 600; k++) begin
            wr(8'(k));
            repeat (3) tick();
        end
        wait_drain("t4_drain", 200);
        check("t4_max_count_le2", 64'(max_cnt <= 2), 64'd1);
        check("t4_one_burst", 64'(busy_falls), 64'd1);

        // 5) async reset during 2nd dibit of a payload byte
        wr(8'($urandom));
        wr(8'($urandom));
        wr(8'($urandom));
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_clear",
              64'({tx_dout, busy, wr_count, wr_full, overflow}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        wr(8'($urandom));
        wait_drain("t5_drain", 100);

        // 6) second burst shortly after the first still gets full preamble
        wr(8'h3C);
        wait_drain("t6_drain_a", 100);
        wr(8'hC3);
        wait_drain("t6_drain_b", 100);

        // random bursts with random spacing
        for (int bidx = 0; bidx < 40; bidx++) begin
            len = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                wr(8'($urandom));
                gap = int'($urandom_range(0, 12));
                repeat (gap) tick();
            end
            gap = int'($urandom_range(0, 20));
            repeat (gap) tick();
        end
        wait_drain("rand_drain", 200);

        repeat (3) tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("rx_bytes_seen", 64'(rx_bytes > 800), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
